// File: rtl/can_pkg.sv
// Shared CAN receive-path constants, header field record and DLC-to-payload helper.
package can_pkg;

  localparam int MSG_W         = 103;
  localparam int STD_HDR       = 19;
  localparam int EXT_HDR       = 39;
  localparam int IDE_POS       = 13;
  localparam int RTR_STD_POS   = 12;
  localparam int RTR_EXT_POS   = 32;
  localparam int DLC_STD_POS   = 15;
  localparam int DLC_EXT_POS   = 35;
  localparam int MAX_DATA_BITS = 64;

  typedef struct packed {
    logic       ide;
    logic       rtr;
    logic [3:0] dlc;
  } can_hdr_t;

  // Remote frames carry no payload; DLC codes above 8 still mean 8 bytes.
  function automatic logic [6:0] dlc_to_bits(input logic [3:0] dlc, input logic rtr);
    logic [6:0] bits;
    if (rtr)
      bits = 7'd0;
    else if (dlc >= 4'd8)
      bits = 7'(MAX_DATA_BITS);
    else
      bits = {dlc, 3'b000};
    return bits;
  endfunction

endpackage

// File: rtl/can_rx_fielddec.sv
// Bit position counter and on-the-fly IDE/RTR/DLC decode for the CAN receive shift register.
module can_rx_fielddec
  import can_pkg::*;
#(
  parameter int WIDTH = MSG_W,
  parameter int CNTW  = 7
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            accept,
  input  logic            bitin,
  output logic            shift_en,
  output logic [CNTW-1:0] bitcount,
  output logic            ide,
  output logic            rtr,
  output logic [3:0]      dlc,
  output logic            data_done,
  output logic            overflow
);

  localparam logic [CNTW-1:0] FULL = CNTW'(WIDTH);

  logic [CNTW-1:0] cnt_reg, cnt_next;
  can_hdr_t        hdr_reg, hdr_next;
  logic            dd_reg, dd_next;
  logic            ov_reg, ov_next;
  logic [CNTW-1:0] hdr_len;
  logic [CNTW-1:0] tgt;
  logic [1:0]      dsel_std, dsel_ext;

  // DLC is sent MSB first, so the bit index counts down across the field.
  assign dsel_std = 2'(CNTW'(DLC_STD_POS + 3) - cnt_reg);
  assign dsel_ext = 2'(CNTW'(DLC_EXT_POS + 3) - cnt_reg);

  always_comb begin
    cnt_next = cnt_reg;
    hdr_next = hdr_reg;
    dd_next  = dd_reg;
    ov_next  = ov_reg;
    shift_en = accept && (cnt_reg < FULL);

    if (shift_en) begin
      cnt_next = cnt_reg + 1'b1;
      if (cnt_reg == CNTW'(IDE_POS))
        hdr_next.ide = bitin;
      // SRR and RTR share position 12 until IDE tells them apart.
      if (cnt_reg == CNTW'(RTR_STD_POS))
        hdr_next.rtr = bitin;
      if (hdr_reg.ide && cnt_reg == CNTW'(RTR_EXT_POS))
        hdr_next.rtr = bitin;
      if (!hdr_reg.ide && cnt_reg >= CNTW'(DLC_STD_POS) && cnt_reg <= CNTW'(DLC_STD_POS + 3))
        hdr_next.dlc[dsel_std] = bitin;
      if (hdr_reg.ide && cnt_reg >= CNTW'(DLC_EXT_POS) && cnt_reg <= CNTW'(DLC_EXT_POS + 3))
        hdr_next.dlc[dsel_ext] = bitin;
    end

    if (accept && !shift_en)
      ov_next = 1'b1;

    // Target uses the post-edge header so the last DLC bit counts at once.
    hdr_len = hdr_next.ide ? CNTW'(EXT_HDR) : CNTW'(STD_HDR);
    tgt     = hdr_len + CNTW'(dlc_to_bits(hdr_next.dlc, hdr_next.rtr));
    if (shift_en && cnt_next >= hdr_len && cnt_next == tgt)
      dd_next = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      cnt_reg <= '0;
      hdr_reg <= '0;
      dd_reg  <= 1'b0;
      ov_reg  <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      hdr_reg <= hdr_next;
      dd_reg  <= dd_next;
      ov_reg  <= ov_next;
    end
  end

  assign bitcount  = cnt_reg;
  assign ide       = hdr_reg.ide;
  assign rtr       = hdr_reg.rtr;
  assign dlc       = hdr_reg.dlc;
  assign data_done = dd_reg;
  assign overflow  = ov_reg;

endmodule

// File: rtl/can_rx_shiftreg.sv
// CAN receive shift register: assembles destuffed bits into the message image, newest bit at [0].
module can_rx_shiftreg
  import can_pkg::*;
#(
  parameter int WIDTH = MSG_W,
  parameter int CNTW  = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             activ,
  input  logic             shift,
  input  logic             clear,
  input  logic             bitin,
  output logic [WIDTH-1:0] mesout,
  output logic [CNTW-1:0]  bitcount,
  output logic             ide,
  output logic             rtr,
  output logic [3:0]       dlc,
  output logic             data_done,
  output logic             overflow
);

  logic             activ_q;
  logic             accept;
  logic             shift_en;
  logic [WIDTH-1:0] mes_reg, mes_next;

  // Only the rising clock of an activ period may take a bit.
  assign accept = activ & ~activ_q & shift & ~clear;

  always_ff @(posedge clock) begin
    if (!reset)
      activ_q <= 1'b0;
    else
      activ_q <= activ;
  end

  assign mes_next[0] = bitin;
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
      assign mes_next[gi] = mes_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset || clear)
      mes_reg <= '0;
    else if (shift_en)
      mes_reg <= mes_next;
  end

  assign mesout = mes_reg;

  can_rx_fielddec #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_fielddec (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .accept    (accept),
    .bitin     (bitin),
    .shift_en  (shift_en),
    .bitcount  (bitcount),
    .ide       (ide),
    .rtr       (rtr),
    .dlc       (dlc),
    .data_done (data_done),
    .overflow  (overflow)
  );

endmodule
